// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - circular pixel-word buffer with registered ready flags and fill level
module pixel_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int AF_LEVEL   = 3
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            u_i_ready,
    input  logic                            u_r_ready,
    input  logic [DATA_WIDTH-1:0]           data_in,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            i_i_ready,
    output logic                            i_r_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            almost_full
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_WIDTH-1:0] mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_next;
    logic [CNT_W-1:0]      count_next;
    logic                  insert;
    logic                  remove;

    // Handshake flags are registered, so a full queue cannot pass a word through on a pop
    assign insert = u_i_ready && i_i_ready;
    assign remove = u_r_ready && i_r_ready;

    // Explicit wrap keeps non-power-of-2 depths correct
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (insert) begin
            wr_ptr_next = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (remove) begin
            rd_ptr_next = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
        end
    end

    always_comb begin
        count_next = count;
        case ({insert, remove})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            i_i_ready   <= 1'b0;
            i_r_ready   <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            count       <= count_next;
            i_i_ready   <= (count_next != CNT_FULL);
            i_r_ready   <= (count_next != CNT_ZERO);
            almost_full <= (count_next >= CNT_AF);
        end
    end

    // Storage is deliberately left unreset; stale words are masked by i_r_ready below
    always_ff @(posedge clock) begin
        if (insert) begin
            mem[wr_ptr] <= data_in;
        end
    end

    assign data_out = i_r_ready ? mem[rd_ptr] : '0;

endmodule
